addsub_rr_sched: RTL

- Round-robin scheduler that shares one single-cycle BF16/INT8 add unit among NUM_REQ requesters.
- Accepts operand requests with a valid/ready handshake and registers the winner's operands into the adder.
- Tracks each in-flight operation with a requester tag and routes the registered result and overflow back to the originating requester.
- Provides a halt/drain FSM so software or upstream control can quiesce the shared adder.

---
 rtl/addsub_rr_sched.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/addsub_rr_sched.sv
// addsub_rr_sched: round-robin arbiter sharing one registered BF16/INT8 add
// unit among NUM_REQ requesters. Winning operands are registered into the
// adder, each issue carries a requester tag plus the sampled overflow, and
// results are routed back as one-hot response strobes. A RUN/DRAIN/HALTED
// FSM lets upstream control quiesce the adder.
// Optional feature macro: ADDSUB_SUB_EN (honour req_sub by negating operand B).
module addsub_rr_sched #(
   parameter int NUM_REQ   = 4,
   parameter int ADDER_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_vld,
   output logic [NUM_REQ-1:0]      req_rdy,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   input  logic [NUM_REQ-1:0]      req_int8,
   input  logic [NUM_REQ-1:0]      req_sub,
   output logic [15:0]             adder_a,
   output logic [15:0]             adder_b,
   output logic                    adder_int8,
   output logic                    adder_vld,
   input  logic [15:0]             adder_res,
   input  logic                    adder_res_vld,
   input  logic                    adder_ovf,
   input  logic                    halt,
   output logic                    halted,
   output logic [NUM_REQ-1:0]      rsp_vld,
   output logic [15:0]             rsp_res,
   output logic                    rsp_ovf
);

   localparam int unsigned N     = NUM_REQ;
   localparam int unsigned LAT   = ADDER_LAT;
   localparam int unsigned LAST  = ADDER_LAT - 1;
   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(ADDER_LAT + 3);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   cand;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   ptr_inc;
   logic               grant_any;
   logic [15:0]        sel_a;
   logic [15:0]        sel_b;
   logic [15:0]        b_eff;
   logic               sel_int8;
   logic [PTR_W-1:0]   issue_tag;
   logic [LAT-1:0]     tag_vld;
   logic [LAT-1:0]     tag_ovf;
   logic [PTR_W-1:0]   tag_idx [LAT];
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               rsp_any;

   // Round-robin search from ptr upward with wrap; grants only in RUN
   always_comb begin
      req_rdy   = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      if (state == ST_RUN) begin
         for (int unsigned k = 0; k < N; k++) begin
            cand = PTR_W'((32'(ptr) + k) % N);
            if (!grant_any && req_vld[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
         if (grant_any) req_rdy[grant_idx] = 1'b1;
      end
   end

   // Select the winning requester's operands
   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_int8 = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (grant_idx == PTR_W'(k)) begin
            sel_a    = req_a[16*k +: 16];
            sel_b    = req_b[16*k +: 16];
            sel_int8 = req_int8[k];
         end
      end
   end

`ifdef ADDSUB_SUB_EN
   logic sel_sub;

   // Operand B negation for subtract requests (INT8 -128 saturates to +127)
   always_comb begin
      sel_sub = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (grant_idx == PTR_W'(k)) sel_sub = req_sub[k];
      end
      b_eff = sel_b;
      if (sel_sub) begin
         if (sel_int8) begin
            if (sel_b[7:0] == 8'h80) b_eff = 16'h007F;
            else                     b_eff = {8'h00, 8'(~sel_b[7:0] + 8'd1)};
         end else begin
            b_eff = {~sel_b[15], sel_b[14:0]};
         end
      end
   end
`else
   logic unused_sub;
   assign unused_sub = ^req_sub;

   // Subtract disabled: operand B passes unchanged
   always_comb begin
      b_eff = sel_b;
   end
`endif

   assign ptr_inc = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
   assign rsp_any = |rsp_vld;

   // In-flight count: +1 on acceptance, -1 on response
   always_comb begin
      cnt_nxt = cnt;
      if (grant_any && !rsp_any)      cnt_nxt = cnt + 1'b1;
      else if (!grant_any && rsp_any) cnt_nxt = cnt - 1'b1;
   end

   // Issue register: load operands and strobe the adder the cycle after acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         adder_a    <= '0;
         adder_b    <= '0;
         adder_int8 <= 1'b0;
         adder_vld  <= 1'b0;
         issue_tag  <= '0;
      end else begin
         adder_vld <= grant_any;
         if (grant_any) begin
            adder_a    <= sel_a;
            adder_b    <= b_eff;
            adder_int8 <= sel_int8;
            issue_tag  <= grant_idx;
         end
      end
   end

   // Tag/overflow shift register aligned with the adder's result latency
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
         tag_ovf <= '0;
         for (int unsigned s = 0; s < LAT; s++) tag_idx[s] <= '0;
      end else begin
         tag_vld[0] <= adder_vld;
         tag_ovf[0] <= adder_ovf;
         tag_idx[0] <= issue_tag;
         for (int unsigned s = 1; s < LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_ovf[s] <= tag_ovf[s-1];
            tag_idx[s] <= tag_idx[s-1];
         end
      end
   end

   // Route the registered result back to the tagged requester
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld <= '0;
         rsp_res <= '0;
         rsp_ovf <= 1'b0;
      end else begin
         rsp_vld <= '0;
         if (adder_res_vld && tag_vld[LAST]) begin
            rsp_vld[tag_idx[LAST]] <= 1'b1;
            rsp_res                <= adder_res;
            rsp_ovf                <= tag_ovf[LAST];
         end
      end
   end

   // Pointer and in-flight bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
      end else begin
         if (grant_any) ptr <= ptr_inc;
         cnt <= cnt_nxt;
      end
   end

   // Halt/drain FSM; uses the next count so halted rises right after the last response
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RUN;
         halted <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               halted <= 1'b0;
               if (halt) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!halt) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end else if (cnt_nxt == '0) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!halt) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= ST_RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
